logic_cone_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational testcase DUTs: evaluates a fixed XOR/AND/OR logic cone over an `IN_W`-bit input vector and delivers an `OUT_W`-bit result through a `STAGES`-deep valid/ready pipeline. It optionally compacts every delivered result into a MISR signature and counts transfers. Original and optimized netlists can then be compared on one signature value instead of on per-vector dumps. It sits between the testbench stimulus reader and the results writer.

---
 rtl/logic_cone_pipe.sv | 99 +++++++++
 tb/tb_logic_cone_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_cone_pipe.sv
// Pipelined XOR/AND/OR logic cone with valid/ready handshake.
// Define LOGIC_CONE_SIG_EN to add the MISR signature and transfer counter.
module logic_cone_pipe #(
    parameter int              IN_W   = 20,
    parameter int              OUT_W  = 10,
    parameter int              STAGES = 2,
    parameter int              SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    input  logic             clear,
    output logic [SIG_W-1:0] sig,
    output logic [15:0]      count
);

    logic             stage_valid [STAGES];
    logic [OUT_W-1:0] stage_data  [STAGES];
    logic [OUT_W-1:0] cone;
    logic             advance;
    logic             accept;
    logic             transfer;

    always_comb begin
        cone = '0;
        for (int k = 0; k < OUT_W; k++) begin
            cone[k] = (in_data[k % IN_W] ^ in_data[(k + IN_W/2) % IN_W])
                    | (in_data[(2*k + 1) % IN_W] & ~in_data[k % IN_W]);
        end
    end

    // The whole pipe moves as one unit; only a stalled last stage blocks it.
    assign advance   = !(stage_valid[STAGES-1] && !out_ready);
    assign in_ready  = advance;
    assign accept    = in_valid && advance;
    assign out_valid = stage_valid[STAGES-1];
    assign out_data  = stage_data[STAGES-1];
    assign transfer  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_valid[i] <= 1'b0;
                stage_data[i]  <= '0;
            end
        end else if (advance) begin
            stage_valid[0] <= accept;
            stage_data[0]  <= cone;
            for (int i = 1; i < STAGES; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_data[i]  <= stage_data[i-1];
            end
        end
    end

`ifdef LOGIC_CONE_SIG_EN
    logic [SIG_W-1:0] sig_q;
    logic [15:0]      count_q;
    logic [SIG_W-1:0] data_ext;

    always_comb begin
        data_ext = '0;
        data_ext[OUT_W-1:0] = out_data;
    end

    // Clear takes priority so a cleared result never enters the signature.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q   <= '0;
            count_q <= '0;
        end else if (clear) begin
            sig_q   <= '0;
            count_q <= '0;
        end else if (transfer) begin
            sig_q <= {sig_q[SIG_W-2:0], 1'b0}
                   ^ (sig_q[SIG_W-1] ? POLY : '0)
                   ^ data_ext;
            if (count_q != 16'hFFFF) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign sig   = sig_q;
    assign count = count_q;
`else
    logic unused_sig_inputs;
    assign unused_sig_inputs = clear ^ transfer;
    assign sig   = '0;
    assign count = '0;
`endif

endmodule

// File: tb/tb_logic_cone_pipe.sv
// Directed self-checking bench for logic_cone_pipe (default parameters).
module tb_logic_cone_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_data;
    logic        clear;
    logic [15:0] sig;
    logic [15:0] count;

`ifdef LOGIC_CONE_SIG_EN
    localparam bit SIG_EN = 1'b1;
`else
    localparam bit SIG_EN = 1'b0;
`endif

    int errs = 0;
    int checks = 0;

    logic [9:0] exp_tab [8] = '{10'h001, 10'h003, 10'h004, 10'h00A,
                                10'h010, 10'h024, 10'h040, 10'h088};

    logic_cone_pipe dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .clear(clear),
        .sig(sig),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] misr(input logic [15:0] s,
                                         input logic [9:0] d);
        logic [15:0] fb;
        fb = s[15] ? 16'h1021 : 16'h0000;
        return {s[14:0], 1'b0} ^ fb ^ {6'b0, d};
    endfunction

    function automatic logic [31:0] en(input logic [31:0] v);
        return SIG_EN ? v : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          tx;
        int          rx;
        int          ec;
        bit          stalled;
        bit          acc;
        logic [15:0] es;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        clear = 1'b0;
        step();
        step();
        chk("rst_valid", out_valid, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sig", sig, 0);
        chk("rst_count", count, 0);

        in_valid = 1'b1;
        in_data = 20'h00001;
        step();
        in_data = 20'h00002;
        step();
        chk("v1_valid", out_valid, 1);
        chk("v1_data", out_data, 10'h001);
        chk("v1_sig_pre", sig, 0);
        in_data = 20'hFFFFF;
        step();
        in_valid = 1'b0;
        chk("v2_data", out_data, 10'h003);
        chk("v1_sig", sig, en(16'h0001));
        chk("v1_count", count, en(1));
        step();
        chk("v3_valid", out_valid, 1);
        chk("v3_data", out_data, 10'h000);
        chk("v2_sig", sig, en(16'h0001));
        chk("v2_count", count, en(2));
        step();
        chk("drain_valid", out_valid, 0);
        chk("v3_sig", sig, en(16'h0002));
        chk("v3_count", count, en(3));

        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_sig", sig, 0);
        chk("clr_count", count, 0);

        tx = 0;
        rx = 0;
        ec = 0;
        stalled = 1'b0;
        es = '0;
        for (int c = 0; c < 60 && rx < 8; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid = (tx < 8);
            in_data = 20'h00001 << tx;
            #1;
            if (in_valid && !in_ready) stalled = 1'b1;
            acc = in_valid && in_ready;
            if (out_valid && !out_ready) begin
                chk("stall_hold", out_data, exp_tab[rx]);
            end
            if (out_valid && out_ready) begin
                chk("stream_data", out_data, exp_tab[rx]);
                es = misr(es, exp_tab[rx]);
                ec++;
                rx++;
            end
            if (acc) tx++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("stream_rx", rx, 8);
        chk("stream_tx", tx, 8);
        chk("stream_stalled", stalled, 1);
        chk("stream_no_dup", out_valid, 0);
        chk("stream_sig", sig, en(es));
        chk("stream_count", count, en(ec));

        in_valid = 1'b1;
        in_data = 20'h00001;
        step();
        in_valid = 1'b0;
        step();
        chk("clrx_valid", out_valid, 1);
        chk("clrx_data", out_data, 10'h001);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clrx_sig", sig, 0);
        chk("clrx_count", count, 0);
        chk("clrx_delivered", out_valid, 0);

        in_valid = 1'b1;
        in_data = 20'h00004;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("pre_rst_sig", sig, en(16'h0004));
        chk("pre_rst_count", count, en(1));
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 20'h00008;
        step();
        in_data = 20'h00020;
        step();
        in_valid = 1'b0;
        #1;
        chk("full_valid", out_valid, 1);
        chk("full_data", out_data, 10'h00A);
        chk("full_in_ready", in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sig", sig, 0);
        chk("mid_rst_count", count, 0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("no_stale", out_valid, 0);
        end
        chk("post_rst_count", count, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
